wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_load_align.sv | 51 +++++
 rtl/wb_stage.sv | 145 ++++++++++++++
 tb/tb_wb_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the writeback stage. Holds the RISC-V
//               load funct3 encodings and the writeback FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   // Load width/sign encodings carried in funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Writeback FSM states
   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WAIT_RSP = 1'b1
   } wb_state_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load data alignment. Selects the byte/half/word
//               addressed by addr_lo from the raw aligned memory word and
//               sign- or zero-extends it according to funct3. Unknown funct3
//               encodings are treated as a full-word load.
// Ports       : i_funct3  [2:0]  load width/sign encoding
//               i_addr_lo [1:0]  byte offset within the word
//               i_rdata   [31:0] raw aligned memory word
//               o_wdata   [31:0] aligned, extended write data
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
   import wb_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
   end

   // Halfword select ignores addr_lo[0]; misaligned halves are not split
   assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_wdata = i_rdata;
      case (i_funct3)
         F3_LB:   o_wdata = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_wdata = {{16{w_half[15]}}, w_half};
         F3_LBU:  o_wdata = {24'h000000, w_byte};
         F3_LHU:  o_wdata = {16'h0000, w_half};
         default: o_wdata = i_rdata;
      endcase
   end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Pipeline writeback stage. Non-load instructions retire with
//               one-cycle latency; loads wait in WAIT_RSP for the data memory
//               response, which is aligned and written back. A load with no
//               response for LOAD_TIMEOUT cycles is aborted with an err_o pulse.
// Config      : WB_INSTRET_EN - when defined, adds the 64-bit retired
//               instruction counter output instret_o.
// Ports       : clk, rst (async active-low)
//               mem_valid_i/mem_ready_o       MEM-stage handshake
//               mem_rd_i, mem_wen_i, mem_is_load_i, mem_funct3_i,
//               mem_addr_lo_i, mem_result_i   retiring instruction fields
//               dmem_rsp_valid_i, dmem_rdata_i load response
//               reg_waddr_o, reg_wdata_o, reg_wen_o  register-file write port
//               err_o                         load-timeout pulse
//               instret_o [63:0]              (WB_INSTRET_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
   import wb_pkg::*;
#(
   parameter int LOAD_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   output logic        mem_ready_o,
   input  logic [4:0]  mem_rd_i,
   input  logic        mem_wen_i,
   input  logic        mem_is_load_i,
   input  logic [2:0]  mem_funct3_i,
   input  logic [1:0]  mem_addr_lo_i,
   input  logic [31:0] mem_result_i,
   input  logic        dmem_rsp_valid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o,
   output logic        reg_wen_o,
   output logic        err_o
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0] instret_o
`endif
);

   localparam int CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);

   wb_state_t          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [4:0]         r_rd;
   logic               r_wen;
   logic [2:0]         r_funct3;
   logic [1:0]         r_addr_lo;

   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_timeout;
   logic [31:0]        w_load_data;

   assign mem_ready_o = (r_state == ST_IDLE);

   // Timeout fires on the miss cycle that would bring the count to LOAD_TIMEOUT
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_timeout = (w_cnt_inc == CNT_W'(LOAD_TIMEOUT));

   load_align u_load_align (
      .i_funct3  (r_funct3),
      .i_addr_lo (r_addr_lo),
      .i_rdata   (dmem_rdata_i),
      .o_wdata   (w_load_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_rd        <= 5'd0;
         r_wen       <= 1'b0;
         r_funct3    <= 3'd0;
         r_addr_lo   <= 2'd0;
         reg_waddr_o <= 5'd0;
         reg_wdata_o <= 32'd0;
         reg_wen_o   <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         reg_wen_o <= 1'b0;
         err_o     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (mem_valid_i) begin
                  if (mem_is_load_i) begin
                     r_rd      <= mem_rd_i;
                     r_wen     <= mem_wen_i;
                     r_funct3  <= mem_funct3_i;
                     r_addr_lo <= mem_addr_lo_i;
                     r_cnt     <= '0;
                     r_state   <= ST_WAIT_RSP;
                  end else if (mem_wen_i && (mem_rd_i != 5'd0)) begin
                     // Address/data only move on a real write so they hold otherwise
                     reg_wen_o   <= 1'b1;
                     reg_waddr_o <= mem_rd_i;
                     reg_wdata_o <= mem_result_i;
                  end
               end
            end
            ST_WAIT_RSP: begin
               // Response has priority over a coincident timeout
               if (dmem_rsp_valid_i) begin
                  if (r_wen && (r_rd != 5'd0)) begin
                     reg_wen_o   <= 1'b1;
                     reg_waddr_o <= r_rd;
                     reg_wdata_o <= w_load_data;
                  end
                  r_state <= ST_IDLE;
               end else if (w_timeout) begin
                  err_o   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef WB_INSTRET_EN
   logic w_retire;

   // Every accepted non-load and every answered load retires; timeouts do not
   assign w_retire = ((r_state == ST_IDLE) && mem_valid_i && !mem_is_load_i) ||
                     ((r_state == ST_WAIT_RSP) && dmem_rsp_valid_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instret_o <= 64'd0;
      end else if (w_retire) begin
         instret_o <= instret_o + 64'd1;
      end
   end
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed self-checking testbench for wb_stage (LOAD_TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i;
   logic        mem_ready_o;
   logic [4:0]  mem_rd_i;
   logic        mem_wen_i;
   logic        mem_is_load_i;
   logic [2:0]  mem_funct3_i;
   logic [1:0]  mem_addr_lo_i;
   logic [31:0] mem_result_i;
   logic        dmem_rsp_valid_i;
   logic [31:0] dmem_rdata_i;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
   logic        reg_wen_o;
   logic        err_o;
`ifdef WB_INSTRET_EN
   logic [63:0] instret_o;
   logic [63:0] instret_before;
`endif

   int checks   = 0;
   int failures = 0;
   int err_cnt;
   int wen_cnt;
   int busy_cnt;

   always #5 clk = ~clk;

   wb_stage #(.LOAD_TIMEOUT(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_valid_i      (mem_valid_i),
      .mem_ready_o      (mem_ready_o),
      .mem_rd_i         (mem_rd_i),
      .mem_wen_i        (mem_wen_i),
      .mem_is_load_i    (mem_is_load_i),
      .mem_funct3_i     (mem_funct3_i),
      .mem_addr_lo_i    (mem_addr_lo_i),
      .mem_result_i     (mem_result_i),
      .dmem_rsp_valid_i (dmem_rsp_valid_i),
      .dmem_rdata_i     (dmem_rdata_i),
      .reg_waddr_o      (reg_waddr_o),
      .reg_wdata_o      (reg_wdata_o),
      .reg_wen_o        (reg_wen_o),
      .err_o            (err_o)
`ifdef WB_INSTRET_EN
      ,
      .instret_o        (instret_o)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
      mem_valid_i   = 1'b1;
      mem_is_load_i = 1'b1;
      mem_wen_i     = 1'b1;
      mem_rd_i      = rd;
      mem_funct3_i  = f3;
      mem_addr_lo_i = lo;
      step();
      mem_valid_i   = 1'b0;
      mem_is_load_i = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      mem_valid_i = 1'b0; mem_rd_i = 5'd0; mem_wen_i = 1'b0; mem_is_load_i = 1'b0;
      mem_funct3_i = 3'd0; mem_addr_lo_i = 2'd0; mem_result_i = 32'd0;
      dmem_rsp_valid_i = 1'b0; dmem_rdata_i = 32'd0;

      // Reset state
      #12;
      chk("rst_ready", {63'd0, mem_ready_o}, 64'd1);
      chk("rst_wen",   {63'd0, reg_wen_o},   64'd0);
      chk("rst_waddr", {59'd0, reg_waddr_o}, 64'd0);
      chk("rst_wdata", {32'd0, reg_wdata_o}, 64'd0);
      chk("rst_err",   {63'd0, err_o},       64'd0);
      @(negedge clk); rst = 1'b1;
      step();

      // Non-load rd=5 then back-to-back second accept
      mem_valid_i = 1'b1; mem_is_load_i = 1'b0; mem_wen_i = 1'b1;
      mem_rd_i = 5'd5; mem_result_i = 32'h1234_5678;
      step();
      chk("nl1_wen",   {63'd0, reg_wen_o},   64'd1);
      chk("nl1_waddr", {59'd0, reg_waddr_o}, 64'd5);
      chk("nl1_wdata", {32'd0, reg_wdata_o}, 64'h1234_5678);
      chk("nl1_ready", {63'd0, mem_ready_o}, 64'd1);
      mem_rd_i = 5'd7; mem_result_i = 32'hCAFE_F00D;
      step();
      chk("nl2_wen",   {63'd0, reg_wen_o},   64'd1);
      chk("nl2_waddr", {59'd0, reg_waddr_o}, 64'd7);
      chk("nl2_wdata", {32'd0, reg_wdata_o}, 64'hCAFE_F00D);
      chk("nl2_ready", {63'd0, mem_ready_o}, 64'd1);

      // Non-load to rd=0: no write, address/data hold
      mem_rd_i = 5'd0; mem_result_i = 32'hDEAD_BEEF;
      step();
      mem_valid_i = 1'b0;
      chk("nl_rd0_wen",   {63'd0, reg_wen_o},   64'd0);
      chk("hold_waddr",   {59'd0, reg_waddr_o}, 64'd7);
      chk("hold_wdata",   {32'd0, reg_wdata_o}, 64'hCAFE_F00D);

      // Response ignored while idle
      dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
      step();
      dmem_rsp_valid_i = 1'b0;
      chk("idle_rsp_wen", {63'd0, reg_wen_o}, 64'd0);

      // LB addr_lo=3, response in the 4th waiting cycle
      issue_load(5'd9, 3'b000, 2'd3);
      for (int i = 0; i < 4; i++) begin
         chk("lb_busy_ready", {63'd0, mem_ready_o}, 64'd0);
         if (i == 3) begin
            dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h80FF_0000;
         end
         step();
      end
      dmem_rsp_valid_i = 1'b0;
      chk("lb_wen",   {63'd0, reg_wen_o},   64'd1);
      chk("lb_waddr", {59'd0, reg_waddr_o}, 64'd9);
      chk("lb_wdata", {32'd0, reg_wdata_o}, 64'hFFFF_FF80);
      chk("lb_ready", {63'd0, mem_ready_o}, 64'd1);

      // LHU / LH addr_lo=2 on 0xBEEF0001
      issue_load(5'd10, 3'b101, 2'd2);
      dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'hBEEF_0001;
      step();
      dmem_rsp_valid_i = 1'b0;
      chk("lhu_wen",   {63'd0, reg_wen_o},   64'd1);
      chk("lhu_wdata", {32'd0, reg_wdata_o}, 64'h0000_BEEF);
      issue_load(5'd11, 3'b001, 2'd2);
      dmem_rsp_valid_i = 1'b1;
      step();
      dmem_rsp_valid_i = 1'b0;
      chk("lh_waddr", {59'd0, reg_waddr_o}, 64'd11);
      chk("lh_wdata", {32'd0, reg_wdata_o}, 64'hFFFF_BEEF);

      // LBU addr_lo=1 and unknown funct3 treated as LW
      issue_load(5'd12, 3'b100, 2'd1);
      dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h1234_A6C3;
      step();
      dmem_rsp_valid_i = 1'b0;
      chk("lbu_wdata", {32'd0, reg_wdata_o}, 64'h0000_00A6);
      issue_load(5'd13, 3'b111, 2'd1);
      dmem_rsp_valid_i = 1'b1;
      step();
      dmem_rsp_valid_i = 1'b0;
      chk("f3inv_wdata", {32'd0, reg_wdata_o}, 64'h1234_A6C3);

      // Load to rd=0: retires without a write
`ifdef WB_INSTRET_EN
      instret_before = instret_o;
`endif
      issue_load(5'd0, 3'b010, 2'd0);
      dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h0BAD_F00D;
      step();
      dmem_rsp_valid_i = 1'b0;
      chk("ld_rd0_wen",   {63'd0, reg_wen_o},   64'd0);
      chk("ld_rd0_ready", {63'd0, mem_ready_o}, 64'd1);
`ifdef WB_INSTRET_EN
      chk("ld_rd0_instret", instret_o, instret_before + 64'd1);
`endif

      // Timeout: no response, 8 waiting cycles then one err pulse
      issue_load(5'd4, 3'b010, 2'd0);
      err_cnt = 0; wen_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!mem_ready_o) busy_cnt++;
         if (err_o) err_cnt++;
         if (reg_wen_o) wen_cnt++;
         step();
      end
      chk("to_err_pulses", 64'(err_cnt),  64'd1);
      chk("to_no_write",   64'(wen_cnt),  64'd0);
      chk("to_busy_cycles", 64'(busy_cnt), 64'd8);
      chk("to_ready",      {63'd0, mem_ready_o}, 64'd1);

      // Response in the same cycle the timeout would fire: response wins
      issue_load(5'd6, 3'b010, 2'd0);
      for (int i = 0; i < 7; i++) step();
      dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'hA5A5_0F0F;
      step();
      dmem_rsp_valid_i = 1'b0;
      chk("tie_wen",   {63'd0, reg_wen_o},   64'd1);
      chk("tie_wdata", {32'd0, reg_wdata_o}, 64'hA5A5_0F0F);
      chk("tie_err",   {63'd0, err_o},       64'd0);

      // Reset while waiting, then a stale response after release
      issue_load(5'd8, 3'b010, 2'd0);
      step();
      #2 rst = 1'b0;
      #1;
      chk("rstw_ready", {63'd0, mem_ready_o}, 64'd1);
      chk("rstw_wdata", {32'd0, reg_wdata_o}, 64'd0);
      @(negedge clk); rst = 1'b1;
      dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
      step();
      dmem_rsp_valid_i = 1'b0;
      chk("rstw_wen",   {63'd0, reg_wen_o},   64'd0);
      chk("rstw_waddr", {59'd0, reg_waddr_o}, 64'd0);
      chk("rstw_wdata2",{32'd0, reg_wdata_o}, 64'd0);
      chk("rstw_err",   {63'd0, err_o},       64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_wb_stage
`default_nettype wire
